// File: rtl/taxi_led_ctrl.sv
// Front-panel LED controller: per-channel link/activity/fault LEDs plus a shared
// board heartbeat. All outputs are registered and hold the physical pin level.
module taxi_led_ctrl #(
  parameter int CNT            = 2,
  parameter int HB_COUNT       = 62500000,
  parameter int ACT_COUNT      = 6250000,
  parameter int SYNC_STAGES    = 2,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hb_en,
  input  logic [CNT-1:0] link_up,
  input  logic [CNT-1:0] fault,
  input  logic [CNT-1:0] act_pulse,
  output logic [CNT-1:0] led_link,
  output logic           led_hb,
  output logic           led_fault_any
);

  localparam int HB_W  = (HB_COUNT > 1) ? $clog2(HB_COUNT) : 1;
  localparam int ACT_W = (ACT_COUNT > 1) ? $clog2(ACT_COUNT) : 1;

  localparam logic [HB_W-1:0]  HB_RELOAD  = HB_W'(HB_COUNT - 1);
  localparam logic [ACT_W-1:0] ACT_RELOAD = ACT_W'(ACT_COUNT - 1);
  localparam logic [HB_W-1:0]  HB_ONE     = HB_W'(1);
  localparam logic [ACT_W-1:0] ACT_ONE    = ACT_W'(1);

  localparam logic PIN_LIT   = ~LED_ACTIVE_LOW;
  localparam logic PIN_UNLIT = LED_ACTIVE_LOW;

  typedef enum logic [2:0] {
    ST_DOWN    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ACT_OFF = 3'd2,
    ST_ACT_ON  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // Heartbeat: the output flop itself carries the blink phase.
  logic [HB_W-1:0] hb_cnt_q;
  logic            led_hb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q <= HB_RELOAD;
      led_hb_q <= PIN_UNLIT;
    end else if (!hb_en) begin
      hb_cnt_q <= HB_RELOAD;
      led_hb_q <= PIN_UNLIT;
    end else if (hb_cnt_q == '0) begin
      hb_cnt_q <= HB_RELOAD;
      led_hb_q <= ~led_hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q - HB_ONE;
    end
  end

  assign led_hb = led_hb_q;

  logic [CNT-1:0] fault_s_vec;
  logic           fault_any_d;
  logic           fault_any_q;

  assign fault_any_d = (|fault_s_vec) ? PIN_LIT : PIN_UNLIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_any_q <= PIN_UNLIT;
    end else begin
      fault_any_q <= fault_any_d;
    end
  end

  assign led_fault_any = fault_any_q;

  genvar gi;
  generate
    for (gi = 0; gi < CNT; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] link_sync_q;
      logic [SYNC_STAGES-1:0] fault_sync_q;
      logic                   link_s;
      logic                   fault_s;
      state_t                 state_q;
      logic [ACT_W-1:0]       cnt_q;
      logic                   pend_q;
      logic                   led_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          link_sync_q  <= '0;
          fault_sync_q <= '0;
        end else begin
          link_sync_q  <= {link_sync_q[SYNC_STAGES-2:0], link_up[gi]};
          fault_sync_q <= {fault_sync_q[SYNC_STAGES-2:0], fault[gi]};
        end
      end

      assign link_s          = link_sync_q[SYNC_STAGES-1];
      assign fault_s         = fault_sync_q[SYNC_STAGES-1];
      assign fault_s_vec[gi] = fault_s;
      assign led_link[gi]    = led_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_DOWN;
          cnt_q   <= '0;
          pend_q  <= 1'b0;
          led_q   <= PIN_UNLIT;
        end else if (fault_s) begin
          pend_q <= 1'b0;
          if (state_q != ST_FAULT) begin
            // Fault blink always starts in the lit half.
            state_q <= ST_FAULT;
            cnt_q   <= ACT_RELOAD;
            led_q   <= PIN_LIT;
          end else if (cnt_q == '0) begin
            cnt_q <= ACT_RELOAD;
            led_q <= ~led_q;
          end else begin
            cnt_q <= cnt_q - ACT_ONE;
          end
        end else begin
          case (state_q)
            ST_DOWN: begin
              if (link_s) begin
                state_q <= ST_IDLE;
                led_q   <= PIN_LIT;
              end else begin
                led_q <= PIN_UNLIT;
              end
            end
            ST_FAULT: begin
              cnt_q  <= '0;
              pend_q <= 1'b0;
              if (link_s) begin
                state_q <= ST_IDLE;
                led_q   <= PIN_LIT;
              end else begin
                state_q <= ST_DOWN;
                led_q   <= PIN_UNLIT;
              end
            end
            ST_IDLE, ST_ACT_OFF, ST_ACT_ON: begin
              if (!link_s) begin
                state_q <= ST_DOWN;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                led_q   <= PIN_UNLIT;
              end else if (state_q == ST_IDLE) begin
                if (act_pulse[gi]) begin
                  state_q <= ST_ACT_OFF;
                  cnt_q   <= ACT_RELOAD;
                  led_q   <= PIN_UNLIT;
                end
              end else if (state_q == ST_ACT_OFF) begin
                // A pulse on the expiry clock still counts toward the next cycle.
                pend_q <= pend_q | act_pulse[gi];
                if (cnt_q == '0) begin
                  state_q <= ST_ACT_ON;
                  cnt_q   <= ACT_RELOAD;
                  led_q   <= PIN_LIT;
                end else begin
                  cnt_q <= cnt_q - ACT_ONE;
                end
              end else begin
                if (cnt_q == '0) begin
                  if (pend_q || act_pulse[gi]) begin
                    state_q <= ST_ACT_OFF;
                    cnt_q   <= ACT_RELOAD;
                    pend_q  <= 1'b0;
                    led_q   <= PIN_UNLIT;
                  end else begin
                    state_q <= ST_IDLE;
                  end
                end else begin
                  cnt_q  <= cnt_q - ACT_ONE;
                  pend_q <= pend_q | act_pulse[gi];
                end
              end
            end
            default: begin
              state_q <= ST_DOWN;
              cnt_q   <= '0;
              pend_q  <= 1'b0;
              led_q   <= PIN_UNLIT;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_taxi_led_ctrl.sv
// Directed bench for taxi_led_ctrl: table-driven link/activity vectors plus
// hand-written heartbeat, fault and mid-blink reset sequences.
module tb_taxi_led_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hb_en = 1'b0;
  logic [1:0] link_up = '0;
  logic [1:0] fault = '0;
  logic [1:0] act_pulse = '0;
  logic [1:0] led_link;
  logic       led_hb;
  logic       led_fault_any;

  int checks = 0;
  int errors = 0;

  taxi_led_ctrl #(
    .CNT(2),
    .HB_COUNT(8),
    .ACT_COUNT(4),
    .SYNC_STAGES(2),
    .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hb_en(hb_en),
    .link_up(link_up),
    .fault(fault),
    .act_pulse(act_pulse),
    .led_link(led_link),
    .led_hb(led_hb),
    .led_fault_any(led_fault_any)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] link;
    logic [1:0] flt;
    logic [1:0] act;
    logic [1:0] exp_led;
    logic       exp_fa;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [1:0] link, input logic [1:0] flt,
                     input logic [1:0] act, input logic [1:0] exp_led, input logic exp_fa);
    vec_t v;
    v.link = link; v.flt = flt; v.act = act; v.exp_led = exp_led; v.exp_fa = exp_fa;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector table: hb_en held low, so led_hb must stay unlit throughout.
    add(2, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1);  // link0 crossing the synchronizer
    add(2, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1);  // lit on the third clock
    add(2, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1);  // link drop propagating
    add(1, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
    add(2, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1);
    add(2, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1);
    // single pulse (channel 1 is DOWN and must ignore its pulse)
    add(1, 2'b01, 2'b00, 2'b11, 2'b11, 1'b1);
    add(3, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1);
    add(6, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1);
    // coalescing: pulses at cycle clocks 1, 2 and 6
    add(1, 2'b01, 2'b00, 2'b01, 2'b11, 1'b1);
    add(1, 2'b01, 2'b00, 2'b01, 2'b11, 1'b1);
    add(2, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1);
    add(1, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1);
    add(1, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1);
    add(2, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1);
    add(4, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1);
    add(6, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1);
    // pulse on the final ACT_ON clock
    add(1, 2'b01, 2'b00, 2'b01, 2'b11, 1'b1);
    add(3, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1);
    add(4, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1);
    add(1, 2'b01, 2'b00, 2'b01, 2'b11, 1'b1);
    add(3, 2'b01, 2'b00, 2'b00, 2'b11, 1'b1);
    add(6, 2'b01, 2'b00, 2'b00, 2'b10, 1'b1);

    // Reset and heartbeat
    hb_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led_link", 32'(led_link), 32'h3);
    chk("rst_led_hb", 32'(led_hb), 32'h1);
    chk("rst_fault_any", 32'(led_fault_any), 32'h1);
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("hb_phase", 32'(led_hb), ((k / 8) % 2 == 1) ? 32'h0 : 32'h1);
    end
    $display("heartbeat: 24 clocks, led_hb=%b", led_hb);
    hb_en = 1'b0;
    step();
    chk("hb_disable", 32'(led_hb), 32'h1);

    // Table-driven link and activity vectors
    foreach (vecs[i]) begin
      link_up   = vecs[i].link;
      fault     = vecs[i].flt;
      act_pulse = vecs[i].act;
      step();
      $display("vec %0d: link=%b act=%b -> led_link=%b fault_any=%b hb=%b",
               i, vecs[i].link, vecs[i].act, led_link, led_fault_any, led_hb);
      chk("vec_led_link", 32'(led_link), 32'(vecs[i].exp_led));
      chk("vec_fault_any", 32'(led_fault_any), 32'(vecs[i].exp_fa));
      chk("vec_led_hb", 32'(led_hb), 32'h1);
    end
    act_pulse = '0;

    // Fault priority on channel 1 during ACT_OFF
    link_up = 2'b11;
    repeat (3) step();
    chk("ch1_link_lit", 32'(led_link), 32'h0);
    act_pulse = 2'b10;
    step();
    act_pulse = 2'b00;
    chk("ch1_act_off", 32'(led_link[1]), 32'h1);
    fault = 2'b10;
    step();
    chk("fault_k1_led", 32'(led_link[1]), 32'h1);
    step();
    chk("fault_k2_led", 32'(led_link[1]), 32'h1);
    chk("fault_k2_any", 32'(led_fault_any), 32'h1);
    for (int k = 3; k <= 14; k++) begin
      step();
      $display("fault clk %0d: led_link=%b fault_any=%b", k, led_link, led_fault_any);
      chk("fault_blink", 32'(led_link[1]), (((k - 3) / 4) % 2 == 1) ? 32'h1 : 32'h0);
      chk("fault_any_lit", 32'(led_fault_any), 32'h0);
      chk("fault_ch0_indep", 32'(led_link[0]), 32'h0);
    end
    fault = 2'b00;
    step();
    step();
    chk("fault_clear_any_hold", 32'(led_fault_any), 32'h0);
    step();
    chk("fault_clear_idle", 32'(led_link[1]), 32'h0);
    chk("fault_clear_any", 32'(led_fault_any), 32'h1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_fault_steady", 32'(led_link), 32'h0);
    end

    // Asynchronous reset in the middle of a blink
    hb_en = 1'b1;
    repeat (8) step();
    chk("hb_lit_before_rst", 32'(led_hb), 32'h0);
    act_pulse = 2'b01;
    step();
    act_pulse = 2'b00;
    chk("rst_blink_off", 32'(led_link), 32'h1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led_link", 32'(led_link), 32'h3);
    chk("async_rst_led_hb", 32'(led_hb), 32'h1);
    chk("async_rst_fault_any", 32'(led_fault_any), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    hb_en = 1'b0;
    rst_n = 1'b1;
    step();
    chk("relink_k1", 32'(led_link), 32'h3);
    step();
    chk("relink_k2", 32'(led_link), 32'h3);
    step();
    chk("relink_k3", 32'(led_link), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      $display("post reset clk %0d: led_link=%b", k + 4, led_link);
      chk("no_residual_blink", 32'(led_link), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
